tick_scheduler: RTL and testbench

Generates single-cycle clock-enable strobes ("ticks") for the game logic from the 100 MHz board clock. Replaces the derived-clock divider so every consumer (keypad/7-seg scan, display refresh, game step) runs on `sys_clk_in` and qualifies its logic with a tick. It sequences all channels together (idle/run/hold) and reprograms any channel's rate through a valid/ready config port. New divisors take effect glitch-free at that channel's wrap point.

---
 rtl/tick_sched_pkg.sv | 16 +
 rtl/tick_channel.sv | 57 +++++
 rtl/tick_scheduler.sv | 81 ++++++++
 tb/tb_tick_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
package tick_sched_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned DIV_W    = 32;
  localparam int unsigned DEF_DIV0 = CLK_HZ / 2000;
  localparam int unsigned DEF_DIV1 = CLK_HZ / 50;
  localparam int unsigned DEF_DIV2 = CLK_HZ / 10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: wrap counter with an active divisor and a shadow divisor
// that is swapped in at the wrap point (or at once when not counting).
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned      DIV_W   = tick_sched_pkg::DIV_W,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             sys_clk_in,
  input  logic             sys_rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;
  logic             active;
  logic             wrap;

  assign active = run && (div != '0);
  assign wrap   = active && (cnt == div - 1'b1);

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      div      <= RST_DIV;
      pend_div <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= wrap;
      if (load) begin
        pend_div <= cfg_div;
        pend     <= 1'b1;
      end
      if (clear || wrap) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt + 1'b1;
      end
      // Not counting (idle/hold/disabled): apply at once from a zero count.
      if (pend && (!active || wrap)) begin
        div  <= pend_div;
        pend <= 1'b0;
        if (!active) begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Clock-enable tick generator: run/hold/idle sequencer over NUM_CH channels
// with a valid/ready port for reprogramming channel divisors.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DIV_W    = tick_sched_pkg::DIV_W,
  parameter int unsigned DEF_DIV0 = tick_sched_pkg::DEF_DIV0,
  parameter int unsigned DEF_DIV1 = tick_sched_pkg::DEF_DIV1,
  parameter int unsigned DEF_DIV2 = tick_sched_pkg::DEF_DIV2,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk_in,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [1:0]        state
);

  state_t            state_q;
  state_t            state_n;
  logic              run;
  logic              clear;
  logic              accept;
  logic [NUM_CH-1:0] pend;

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (stop) begin
      if (state_q != IDLE) state_n = IDLE;
    end else if (pause) begin
      if (state_q == RUN) state_n = HOLD;
    end else if (start) begin
      if (state_q != RUN) state_n = RUN;
    end
  end

  // Channels count only while staying in RUN, so a pause/stop edge freezes
  // or clears them on that same edge and a start edge does not count.
  assign run       = (state_q == RUN) && (state_n == RUN);
  assign clear     = (state_n == IDLE);
  assign cfg_ready = ~|pend;
  assign accept    = cfg_valid && cfg_ready;
  assign state     = state_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned RST = (i == 0) ? DEF_DIV0 : (i == 1) ? DEF_DIV1 : DEF_DIV2;
    logic load;

    assign load = accept && (int'(cfg_ch) == i);

    tick_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (DIV_W'(RST))
    ) u_ch (
      .sys_clk_in (sys_clk_in),
      .sys_rst_n  (sys_rst_n),
      .run        (run),
      .clear      (clear),
      .load       (load),
      .cfg_div    (cfg_div),
      .tick       (tick[i]),
      .pend       (pend[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler with short sim divisors 4/10/0.
module tb_tick_scheduler;

  logic        sys_clk_in;
  logic        sys_rst_n;
  logic        start;
  logic        pause;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [2:0]  tick;
  logic [1:0]  state;

  typedef struct packed {
    logic [2:0] tick;
    logic       ready;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks;
  int   failures;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  tick_scheduler #(
    .NUM_CH   (3),
    .DIV_W    (32),
    .DEF_DIV0 (4),
    .DEF_DIV1 (10),
    .DEF_DIV2 (0)
  ) dut (
    .sys_clk_in (sys_clk_in),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .tick       (tick),
    .state      (state)
  );

  initial sys_clk_in = 1'b0;
  always #5 sys_clk_in = ~sys_clk_in;

  task automatic step();
    @(posedge sys_clk_in);
    #1;
  endtask

  function automatic exp_t mk(input bit t0, input bit t1, input bit t2,
                              input bit r, input logic [1:0] s);
    exp_t x;
    x.tick  = {t2, t1, t0};
    x.ready = r;
    x.st    = s;
    return x;
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start = 0; pause = 0; stop = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
    repeat (2) step();
    checks++;
    if (tick !== 3'b000) begin
      failures++;
      $display("FAIL reset_tick: got %b expected 000", tick);
    end
    checks++;
    if (state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %b expected 00", state);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", cfg_ready);
    end
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    start = 1'b1;
    for (int k = 0; k <= 20; k++)
      sb.push_back(mk(k > 0 && k % 4 == 0, k > 0 && k % 10 == 0, 1'b0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      start = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL start: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_pause_resume();
    for (int k = 21; k <= 26; k++)
      sb.push_back(mk(k % 4 == 0, k % 10 == 0, 1'b0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL pre_pause: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    // ch1 count is now 6, ch0 count is 2
    pause = 1'b1;
    for (int k = 0; k <= 50; k++) sb.push_back(mk(0, 0, 0, 1'b1, S_HOLD));
    while (sb.size() != 0) begin
      step();
      pause = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL hold: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    start = 1'b1;
    for (int k = 0; k <= 15; k++)
      sb.push_back(mk(k > 0 && (2 + k) % 4 == 0, k > 0 && (6 + k) % 10 == 0, 1'b0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      start = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL resume: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_reconfig_wrap();
    // ch0 count is 1 before the accepting edge
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd7;
    for (int j = 0; j <= 18; j++)
      sb.push_back(mk(j == 2 || j == 9 || j == 16, j == 8 || j == 18, 1'b0, j >= 2, S_RUN));
    while (sb.size() != 0) begin
      step();
      cfg_valid = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL reconfig_wrap: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_disabled_apply();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd1;
    for (int j = 0; j <= 12; j++)
      sb.push_back(mk(j == 4 || j == 11, j == 9, j >= 2, j >= 1, S_RUN));
    while (sb.size() != 0) begin
      step();
      cfg_valid = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL disabled_apply: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_simultaneous_cmd();
    start = 1'b1; pause = 1'b1; stop = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back(mk(0, 0, 0, 1'b1, S_IDLE));
    while (sb.size() != 0) begin
      step();
      start = 0; pause = 0; stop = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL all_cmds: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd9;
    for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 0, 1'b1, S_IDLE));
    while (sb.size() != 0) begin
      step();
      cfg_valid = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL bad_ch_cfg: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    // divisors must still be 7/10/1 and counters start from zero
    start = 1'b1;
    for (int k = 0; k <= 21; k++)
      sb.push_back(mk(k > 0 && k % 7 == 0, k > 0 && k % 10 == 0, k > 0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      start = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL restart: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_reset_pending();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd3;
    sb.push_back(mk(0, 0, 1, 1'b0, S_RUN));
    while (sb.size() != 0) begin
      step();
      cfg_valid = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL pend_before_rst: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({tick, cfg_ready, state} !== {3'b000, 1'b1, S_IDLE}) begin
      failures++;
      $display("FAIL async_reset: got tick=%b ready=%b state=%b expected tick=000 ready=1 state=00",
               tick, cfg_ready, state);
    end
    #1;
    sys_rst_n = 1'b1;
    step();
    start = 1'b1;
    for (int k = 0; k <= 20; k++)
      sb.push_back(mk(k > 0 && k % 4 == 0, k > 0 && k % 10 == 0, 1'b0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      start = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL defaults_restored: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  task automatic test_stop_pending();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd5;
    sb.push_back(mk(0, 0, 0, 1'b0, S_RUN));
    while (sb.size() != 0) begin
      step();
      cfg_valid = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL stop_pend_accept: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    stop = 1'b1;
    sb.push_back(mk(0, 0, 0, 1'b1, S_IDLE));
    sb.push_back(mk(0, 0, 0, 1'b1, S_IDLE));
    while (sb.size() != 0) begin
      step();
      stop = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL stop_pend_apply: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
    start = 1'b1;
    for (int k = 0; k <= 10; k++)
      sb.push_back(mk(k > 0 && k % 4 == 0, k > 0 && k % 5 == 0, 1'b0, 1'b1, S_RUN));
    while (sb.size() != 0) begin
      step();
      start = 0;
      e = sb.pop_front();
      checks++;
      if ({tick, cfg_ready, state} !== e) begin
        failures++;
        $display("FAIL stop_pend_run: got tick=%b ready=%b state=%b expected tick=%b ready=%b state=%b",
                 tick, cfg_ready, state, e.tick, e.ready, e.st);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_start();
    test_pause_resume();
    test_reconfig_wrap();
    test_disabled_apply();
    test_simultaneous_cmd();
    test_reset_pending();
    test_stop_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
